// File: rtl/pio_out_ext.sv
// pio_out_ext: Avalon-MM parallel output port with DATA/OUTSET/OUTCLEAR access.
// Build option: define PIO_OUT_EXT_PULSE_EN to add PULSE_LEN, PULSE_MASK, STATUS
// and a pulse engine that auto-clears masked DATA bits a set number of cycles after they rise.
module pio_out_ext #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned           CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  pulse_busy
);
    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_LEN    = 3'd1;
    localparam logic [2:0] A_MASK   = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLR    = 3'd5;

    logic                  wr, wr_data, wr_set, wr_clr;
    logic [DATA_WIDTH-1:0] wd, data_q, data_d, data_wr;
    logic                  unused_wd;

    assign wr        = chipselect && !write_n;
    assign wr_data   = wr && (address == A_DATA);
    assign wr_set    = wr && (address == A_SET);
    assign wr_clr    = wr && (address == A_CLR);
    assign wd        = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign out_port  = data_q;

    // DATA after the bus write alone, before any pulse expiry clear
    always_comb begin
        data_wr = wr_data ? wd :
                  wr_set  ? (data_q | wd) :
                  wr_clr  ? (data_q & ~wd) : data_q;
    end

`ifdef PIO_OUT_EXT_PULSE_EN
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, len_q, len_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic                  trig;

    assign pulse_busy = (state_q == RUN);

    // a trigger is a masked DATA bit rising through a DATA or OUTSET write
    assign trig = (wr_data || wr_set) && (len_q != '0) && |(mask_q & ~data_q & data_wr);

    // configuration registers keep their value unless addressed
    always_comb begin
        len_d  = (wr && address == A_LEN)  ? writedata[CNT_WIDTH-1:0]  : len_q;
        mask_d = (wr && address == A_MASK) ? writedata[DATA_WIDTH-1:0] : mask_q;
    end

    // pulse next state: retrigger reloads, otherwise count down and clear masked bits on expiry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_wr;
        if (trig) begin
            state_d = RUN;
            cnt_d   = len_q;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
                data_d  = data_wr & ~mask_q;
            end
        end
    end

    // pulse state and configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mask_q  <= mask_d;
        end
    end

    // read mux, zero-extended; write-only and reserved addresses read as zero
    always_comb begin
        readdata = 32'd0;
        case (address)
            A_DATA:   readdata = 32'(data_q);
            A_LEN:    readdata = 32'(len_q);
            A_MASK:   readdata = 32'(mask_q);
            A_STATUS: readdata = {31'd0, pulse_busy};
            default:  readdata = 32'd0;
        endcase
    end
`else
    assign pulse_busy = 1'b0;
    assign data_d     = data_wr;

    // read mux: only DATA is readable without the pulse engine
    always_comb begin
        readdata = (address == A_DATA) ? 32'(data_q) : 32'd0;
    end
`endif

    // output data register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) data_q <= RESET_VALUE;
        else          data_q <= data_d;
    end
endmodule
